vga_sync_decoder: RTL and testbench
===================================

# vga_sync_decoder

- Receiving end of the VGA sync interface: samples active-low `hsync`/`vsync` on the pixel clock and recovers pixel coordinates plus a display window.
- Measures line and frame lengths, checks them against the configured timing, and reports lock and sync errors.
- Used as the bench-side monitor for the sync generator, and as the front end of any block that consumes an external VGA sync stream.

## Interface
Parameters:
- `H_ACTIVE`, 640: visible pixels per line
- `H_SYNC_START`, 656: x of first hsync-low pixel
- `H_SYNC_END`, 752: x of first pixel after hsync pulse
- `H_TOTAL`, 800: clocks per line
- `V_ACTIVE`, 480: visible lines
- `V_SYNC_START`, 490: y of first vsync-low line
- `V_SYNC_END`, 492: y of first line after vsync pulse
- `V_TOTAL`, 525: lines per frame

Ports:
- `VGA_clk`  in  1  pixel clock; the only clock
- `reset`  in  1  asynchronous, active-high
- `hsync`  in  1  active-low, synchronous to `VGA_clk`
- `vsync`  in  1  active-low, synchronous to `VGA_clk`
- `x_pos`  out  10  recovered x of the sample taken on the previous edge
- `y_pos`  out  10  recovered line number
- `display_enable`  out  1  `locked && x_pos < H_ACTIVE && y_pos < V_ACTIVE`; combinational from registers
- `locked`  out  1  timing verified
- `h_period`  out  11  last measured clocks between hsync falls
- `v_period`  out  11  last measured hsync falls between vsync falls
- `frame_start`  out  1  one-cycle pulse on each vsync fall
- `sync_err`  out  1  one-cycle pulse on a mismatch while in H_OK or LOCKED

## Operation
- **Edge detect:** `hs_q`/`vs_q` hold the previous samples.
  - `hfall = hs_q & ~hsync`, `hrise = ~hs_q & hsync`; same form for `vfall`.
  - `hs_q`/`vs_q` reset to 1.
- **x recovery:**
  - On `hfall`: `x_pos <= H_SYNC_START`.
  - Otherwise: `x_pos <= (x_pos == H_TOTAL-1) ? 0 : x_pos+1`.
- **y recovery:**
  - On `vfall`: `y_pos <= V_SYNC_START`. If this coincides with the x wrap, the load wins.
  - Otherwise, on the x wrap: `y_pos <= (y_pos == V_TOTAL-1) ? 0 : y_pos+1`.
- **Line measure:** `h_cnt` is 11 bits and saturates at 2047.
  - On `hfall`: `h_period <= h_cnt`, `h_cnt <= 1`.
  - Otherwise `h_cnt` increments.
- **Pulse width:** `hw_cnt` counts clocks with `hsync` low and is checked on `hrise`.
  - Expected width is `H_SYNC_END - H_SYNC_START` (96).
  - On `vsync` rise, the number of hfalls seen while `vsync` was low must equal `V_SYNC_END - V_SYNC_START` (2).
- **Frame measure:** `v_cnt` increments on each `hfall`.
  - On `vfall`: `v_period <= v_cnt + hfall`, `v_cnt <= 0`. A coincident `hfall` is counted in the closing frame.
- **First-edge handling:** `h_seen`/`v_seen` flags mark that a first edge has occurred. Measurements taken before the flag is set are neither checked nor counted as errors.
- **State machine:**
  - **UNLOCKED**
    - Moves to H_OK on an `hfall` with `h_seen` and `h_cnt == H_TOTAL`.
  - **H_OK**
    - Moves to LOCKED on a `vfall` with `v_seen` and `v_cnt + hfall == V_TOTAL`.
    - Any h check failure returns it to UNLOCKED and pulses `sync_err`.
  - **LOCKED**
    - Any failed check returns it to UNLOCKED with a `sync_err` pulse on the next cycle. Failed checks are: period at `hfall`, period at `vfall`, or either pulse width.
  - Coordinates keep free-running in every state.
- `locked` is a registered output, high only in LOCKED.

## Timing
- **Reset values:**
  - `x_pos`, `y_pos`, `h_period`, `v_period` = 0.
  - `locked`, `frame_start`, `sync_err` = 0.
  - `display_enable` = 0.
  - State = UNLOCKED; internal counters and seen flags cleared.
- Asserting `reset` mid-frame clears everything immediately. Relock needs a full line plus a full frame.
- **Latency:**
  - `x_pos` is valid one cycle after the sample: the sample at the hfall edge reads `H_SYNC_START` on the following cycle.
  - `frame_start` and `sync_err` rise on the cycle after the triggering edge and last exactly one cycle.
- **Lock time**, nominal stream from reset:
  - First hfall sets `h_seen`; the second hfall enters H_OK.
  - First vfall sets `v_seen`; the second vfall enters LOCKED. `locked` rises on the following cycle.
- Widths: all comparisons use 11-bit values; `x_pos`/`y_pos` never exceed `H_TOTAL-1`/`V_TOTAL-1` after the first edge.

## Test plan
- **Reset values:** hold `reset` high while toggling syncs → every output stays 0 and `hs_q` = 1.
- **Nominal lock:** nominal 800×525 stream, hsync low for x 656–751, vsync low for lines 490–491 → `h_period` = 800, `v_period` = 525. `locked` rises one cycle after the second vfall, with no `sync_err`.
- **Coordinate alignment:** after lock, `x_pos` = 656 on the cycle after each hfall, `y_pos` = 490 on the cycle after each vfall. `display_enable` is high for exactly 640×480 cycles per frame.
- **Short line:** while locked, one line of 799 clocks → `h_period` = 799, one `sync_err` pulse, `locked` drops. Relock happens on the following good frame.
- **Short pulse:** while locked, one hsync pulse 95 clocks wide → `sync_err` on the cycle after `hrise`, state UNLOCKED.
- **Reset mid-frame:** assert `reset` at line 200 → outputs 0 immediately. After release, `locked` returns only after two vfalls.

Source files
------------

// File: rtl/vga_sync_decoder.sv
// vga_sync_decoder: recovers pixel coordinates and a display window
// from an active-low hsync/vsync stream and verifies its timing.
module vga_sync_decoder #(
   parameter int H_ACTIVE     = 640,
   parameter int H_SYNC_START = 656,
   parameter int H_SYNC_END   = 752,
   parameter int H_TOTAL      = 800,
   parameter int V_ACTIVE     = 480,
   parameter int V_SYNC_START = 490,
   parameter int V_SYNC_END   = 492,
   parameter int V_TOTAL      = 525
) (
   input  logic        VGA_clk,
   input  logic        reset,
   input  logic        hsync,
   input  logic        vsync,
   output logic [9:0]  x_pos,
   output logic [9:0]  y_pos,
   output logic        display_enable,
   output logic        locked,
   output logic [10:0] h_period,
   output logic [10:0] v_period,
   output logic        frame_start,
   output logic        sync_err
);

   localparam logic [1:0] UNLOCKED = 2'd0;
   localparam logic [1:0] H_OK     = 2'd1;
   localparam logic [1:0] LOCKED   = 2'd2;

   localparam logic [9:0]  X_LOAD  = 10'(H_SYNC_START);
   localparam logic [9:0]  X_LAST  = 10'(H_TOTAL - 1);
   localparam logic [9:0]  Y_LOAD  = 10'(V_SYNC_START);
   localparam logic [9:0]  Y_LAST  = 10'(V_TOTAL - 1);
   localparam logic [10:0] H_ACT   = 11'(H_ACTIVE);
   localparam logic [10:0] V_ACT   = 11'(V_ACTIVE);
   localparam logic [10:0] H_TOT   = 11'(H_TOTAL);
   localparam logic [10:0] V_TOT   = 11'(V_TOTAL);
   localparam logic [10:0] H_PW    = 11'(H_SYNC_END - H_SYNC_START);
   localparam logic [10:0] V_PW    = 11'(V_SYNC_END - V_SYNC_START);
   localparam logic [10:0] CNT_MAX = 11'h7FF;

   logic        hs_q, vs_q;
   logic        hfall, hrise, vfall, vrise;
   logic        x_wrap;
   logic [10:0] h_cnt, hw_cnt, v_cnt, vh_cnt, v_sum;
   logic        h_seen, v_seen;
   logic        h_per_bad, h_wid_bad, v_per_bad, v_wid_bad;
   logic [1:0]  state, state_nx;
   logic        err;

   assign hfall  = hs_q & ~hsync;
   assign hrise  = ~hs_q & hsync;
   assign vfall  = vs_q & ~vsync;
   assign vrise  = ~vs_q & vsync;
   assign x_wrap = ~hfall & (x_pos == X_LAST);

   // a coincident hfall belongs to the frame that is closing
   assign v_sum = (v_cnt == CNT_MAX) ? v_cnt : v_cnt + {10'd0, hfall};

   assign h_per_bad = hfall & h_seen & (h_cnt != H_TOT);
   assign h_wid_bad = hrise & h_seen & (hw_cnt != H_PW);
   assign v_per_bad = vfall & v_seen & (v_sum != V_TOT);
   assign v_wid_bad = vrise & v_seen & (vh_cnt != V_PW);

   assign display_enable = locked
                         & ({1'b0, x_pos} < H_ACT)
                         & ({1'b0, y_pos} < V_ACT);

   // previous sync samples for edge detection
   always_ff @(posedge VGA_clk or posedge reset) begin
      if (reset) begin
         hs_q <= 1'b1;
         vs_q <= 1'b1;
      end else begin
         hs_q <= hsync;
         vs_q <= vsync;
      end
   end

   // mark that a first edge has been seen so later measurements are real
   always_ff @(posedge VGA_clk or posedge reset) begin
      if (reset) begin
         h_seen <= 1'b0;
         v_seen <= 1'b0;
      end else begin
         if (hfall) h_seen <= 1'b1;
         if (vfall) v_seen <= 1'b1;
      end
   end

   // free-running coordinates, realigned on each sync fall
   always_ff @(posedge VGA_clk or posedge reset) begin
      if (reset) begin
         x_pos <= '0;
         y_pos <= '0;
      end else begin
         if (hfall)
            x_pos <= X_LOAD;
         else
            x_pos <= (x_pos == X_LAST) ? '0 : x_pos + 10'd1;
         if (vfall)
            y_pos <= Y_LOAD;
         else if (x_wrap)
            y_pos <= (y_pos == Y_LAST) ? '0 : y_pos + 10'd1;
      end
   end

   // line/frame length and sync pulse width measurement
   always_ff @(posedge VGA_clk or posedge reset) begin
      if (reset) begin
         h_cnt    <= '0;
         hw_cnt   <= '0;
         v_cnt    <= '0;
         vh_cnt   <= '0;
         h_period <= '0;
         v_period <= '0;
      end else begin
         if (hfall) begin
            h_period <= h_cnt;
            h_cnt    <= 11'd1;
            hw_cnt   <= 11'd1;
         end else begin
            if (h_cnt != CNT_MAX)
               h_cnt <= h_cnt + 11'd1;
            if (!hsync && hw_cnt != CNT_MAX)
               hw_cnt <= hw_cnt + 11'd1;
         end
         if (vfall) begin
            v_period <= v_sum;
            v_cnt    <= '0;
            vh_cnt   <= {10'd0, hfall};
         end else if (hfall) begin
            if (v_cnt != CNT_MAX)
               v_cnt <= v_cnt + 11'd1;
            if (!vsync && vh_cnt != CNT_MAX)
               vh_cnt <= vh_cnt + 11'd1;
         end
      end
   end

   // lock state machine: line first, then frame; any bad check drops it
   always_comb begin
      state_nx = state;
      err      = 1'b0;
      case (state)
         UNLOCKED: begin
            if (hfall && h_seen && h_cnt == H_TOT)
               state_nx = H_OK;
         end
         H_OK: begin
            if (h_per_bad || h_wid_bad) begin
               state_nx = UNLOCKED;
               err      = 1'b1;
            end else if (vfall && v_seen && v_sum == V_TOT) begin
               state_nx = LOCKED;
            end
         end
         LOCKED: begin
            if (h_per_bad || h_wid_bad || v_per_bad || v_wid_bad) begin
               state_nx = UNLOCKED;
               err      = 1'b1;
            end
         end
         default: state_nx = UNLOCKED;
      endcase
   end

   // state register and registered status pulses
   always_ff @(posedge VGA_clk or posedge reset) begin
      if (reset) begin
         state       <= UNLOCKED;
         locked      <= 1'b0;
         frame_start <= 1'b0;
         sync_err    <= 1'b0;
      end else begin
         state       <= state_nx;
         locked      <= (state_nx == LOCKED);
         frame_start <= vfall;
         sync_err    <= err;
      end
   end

endmodule

// File: tb/tb_vga_sync_decoder.sv
// tb_vga_sync_decoder: drives a scaled-down sync stream and checks
// coordinates, measurements, lock and error pulses via a scoreboard.
module tb_vga_sync_decoder;

   localparam int HA  = 16;
   localparam int HSS = 18;
   localparam int HSE = 22;
   localparam int HT  = 26;
   localparam int VA  = 10;
   localparam int VSS = 12;
   localparam int VSE = 14;
   localparam int VT  = 16;
   localparam int HPW = HSE - HSS;

   logic        clk = 1'b0;
   logic        reset;
   logic        hsync, vsync;
   logic [9:0]  x_pos, y_pos;
   logic        display_enable, locked;
   logic [10:0] h_period, v_period;
   logic        frame_start, sync_err;

   vga_sync_decoder #(
      .H_ACTIVE(HA), .H_SYNC_START(HSS), .H_SYNC_END(HSE), .H_TOTAL(HT),
      .V_ACTIVE(VA), .V_SYNC_START(VSS), .V_SYNC_END(VSE), .V_TOTAL(VT)
   ) dut (
      .VGA_clk(clk),
      .reset(reset),
      .hsync(hsync),
      .vsync(vsync),
      .x_pos(x_pos),
      .y_pos(y_pos),
      .display_enable(display_enable),
      .locked(locked),
      .h_period(h_period),
      .v_period(v_period),
      .frame_start(frame_start),
      .sync_err(sync_err)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int checks = 0;
   int errors = 0;

   // scoreboard queues hold the cycle tag at which each event must show
   int fs_q[$];
   int hx_q[$];
   int err_q[$];
   int lk_q[$];

   // stream generator state
   int gx = 0, gy = 0;
   int line_len = HT;
   int pw = HPW;
   logic ph = 1'b1, pv = 1'b1;
   int arm_eh = 0, arm_er = 0, arm_lk = 0;

   logic lk_prev = 1'b0;
   int de_cnt = 0;
   int last_de = -1;
   logic [45:0] obs;

   task automatic chk(input string tag, input logic [63:0] o,
                      input logic [63:0] e);
      checks++;
      assert (o === e) else begin
         errors++;
         $error("FAIL %s: observed %0d expected %0d", tag, o, e);
      end
   endtask

   task automatic tick();
      logic h, v;
      @(negedge clk);
      h = !(gx >= HSS && gx < HSS + pw);
      v = !(gy >= VSS && gy < VSE);
      if (ph && !h) begin
         hx_q.push_back(cyc + 1);
         if (arm_eh > 0) begin
            arm_eh--;
            if (arm_eh == 0) err_q.push_back(cyc + 1);
         end
      end
      if (!ph && h && arm_er > 0) begin
         arm_er--;
         if (arm_er == 0) err_q.push_back(cyc + 1);
      end
      if (pv && !v) begin
         fs_q.push_back(cyc + 1);
         if (arm_lk > 0) begin
            arm_lk--;
            if (arm_lk == 0) lk_q.push_back(cyc + 1);
         end
      end
      hsync = h;
      vsync = v;
      ph = h;
      pv = v;
      gx++;
      if (gx == line_len) begin
         gx = 0;
         line_len = HT;
         pw = HPW;
         gy = (gy == VT - 1) ? 0 : gy + 1;
      end
   endtask

   task automatic run_to(input int line);
      int n = 0;
      do begin
         tick();
         n++;
      end while (!(gx == 0 && gy == line) && n < 5000);
      chk("run_to_reached", 64'(gx == 0 && gy == line), 64'(1));
   endtask

   task automatic monitor_step();
      logic e;
      e = 1'b0;
      if (fs_q.size() > 0) e = (fs_q[0] == cyc);
      if (e || frame_start) begin
         chk("frame_start", 64'(frame_start), 64'(e));
         if (e) begin
            void'(fs_q.pop_front());
            chk("y_after_vfall", 64'(y_pos), 64'(VSS));
         end
      end
      e = 1'b0;
      if (hx_q.size() > 0) e = (hx_q[0] == cyc);
      if (e) begin
         void'(hx_q.pop_front());
         chk("x_after_hfall", 64'(x_pos), 64'(HSS));
      end
      e = 1'b0;
      if (err_q.size() > 0) e = (err_q[0] == cyc);
      if (e || sync_err) begin
         chk("sync_err", 64'(sync_err), 64'(e));
         if (e) void'(err_q.pop_front());
         if (sync_err) chk("locked_at_err", 64'(locked), 64'(0));
      end
      e = 1'b0;
      if (lk_q.size() > 0) e = (lk_q[0] == cyc);
      if (e || (locked && !lk_prev)) begin
         chk("lock_rise", 64'(locked && !lk_prev), 64'(e));
         if (e) void'(lk_q.pop_front());
      end
      lk_prev = locked;
      if (frame_start) begin
         last_de = de_cnt;
         de_cnt = 0;
      end else begin
         de_cnt += int'(display_enable);
      end
   endtask

   always @(negedge clk) monitor_step();

   initial begin
      reset = 1'b1;
      hsync = 1'b1;
      vsync = 1'b1;
      repeat (3) @(negedge clk);
      // reset held: outputs stay zero whatever the syncs do
      for (int i = 0; i < 12; i++) begin
         @(negedge clk);
         hsync = 1'($urandom_range(0, 1));
         vsync = 1'($urandom_range(0, 1));
         #1;
         obs = {x_pos, y_pos, h_period, v_period,
                locked, frame_start, sync_err, display_enable};
         chk("reset_outputs", 64'(obs), 64'(0));
         chk("reset_hs_q", 64'(dut.hs_q), 64'(1));
      end
      @(negedge clk);
      hsync = 1'b1;
      vsync = 1'b1;
      @(negedge clk);
      reset = 1'b0;

      // nominal lock: second vfall locks
      arm_lk = 2;
      run_to(VSS);
      chk("unlocked_first_frame", 64'(locked), 64'(0));
      run_to(VSS);
      chk("unlocked_before_2nd_vfall", 64'(locked), 64'(0));
      run_to(VSS + 1);
      chk("locked_nominal", 64'(locked), 64'(1));
      chk("h_period_nominal", 64'(h_period), 64'(HT));
      chk("v_period_nominal", 64'(v_period), 64'(VT));
      run_to(VSS + 1);
      chk("de_per_frame", 64'(last_de), 64'(HA * VA));

      // short line while locked
      run_to(3);
      line_len = HT - 1;
      arm_eh = 2;
      arm_lk = 1;
      run_to(5);
      chk("h_period_short", 64'(h_period), 64'(HT - 1));
      chk("unlocked_short_line", 64'(locked), 64'(0));
      run_to(6);
      chk("h_period_recovered", 64'(h_period), 64'(HT));
      run_to(VSS + 1);
      chk("relock_short_line", 64'(locked), 64'(1));

      // narrow hsync pulse while locked
      run_to(3);
      pw = HPW - 1;
      arm_er = 1;
      arm_lk = 1;
      run_to(4);
      chk("unlocked_short_pulse", 64'(locked), 64'(0));
      chk("h_period_pulse", 64'(h_period), 64'(HT));
      run_to(VSS + 1);
      chk("relock_short_pulse", 64'(locked), 64'(1));
      run_to(VSS + 1);
      chk("de_after_relock", 64'(last_de), 64'(HA * VA));

      // reset mid-frame
      run_to(6);
      #2 reset = 1'b1;
      #1;
      obs = {x_pos, y_pos, h_period, v_period,
             locked, frame_start, sync_err, display_enable};
      chk("async_reset_outputs", 64'(obs), 64'(0));
      repeat (3) tick();
      #2 reset = 1'b0;
      arm_lk = 2;
      run_to(VSS + 1);
      chk("unlocked_after_1st_vfall", 64'(locked), 64'(0));
      run_to(VSS + 1);
      chk("relock_after_reset", 64'(locked), 64'(1));
      chk("v_period_after_reset", 64'(v_period), 64'(VT));
      chk("h_period_after_reset", 64'(h_period), 64'(HT));
      repeat (4) tick();
      chk("events_drained", 64'(err_q.size() + lk_q.size()), 64'(0));

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
